// File: rtl/pol2rec.sv
// Polar-to-rectangular converter: iterative CORDIC in rotation mode, one
// micro-rotation per enabled clock, results returned in signed 16.16.
module pol2rec #(
    parameter int unsigned NITER = 32,
    parameter logic [31:0] KINV  = 32'h9B74EDA8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] mod_in,
    input  logic [31:0] angle_in,
    output logic [31:0] x_res,
    output logic [31:0] y_res,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    // Handshake: start is a single-cycle request honoured only in IDLE with
    // enable high; done pulses for one enabled cycle as x_res/y_res update.

    localparam int IW = (NITER > 1) ? $clog2(NITER) : 1;
    localparam logic [IW-1:0]     LAST   = IW'(NITER - 1);
    localparam logic signed [31:0] DEG90  = 32'sh5A000000;
    localparam logic [31:0]        DEG180 = 32'hB4000000;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nx;
    logic [IW-1:0]      i;
    logic signed [33:0] x, y, x_nx, y_nx;
    logic signed [31:0] z, z_nx, z0, atan_i;
    logic               neg, neg0;
    logic [31:0]        x0, x_out, y_out;

    // atan(2^-i) in degrees, signed 8.24, rounded to nearest
    function automatic logic signed [31:0] atan_rom(input logic [IW-1:0] idx);
        case (int'(idx))
            0:       atan_rom = 32'sh2D000000;
            1:       atan_rom = 32'sh1A90A732;
            2:       atan_rom = 32'sh0E094740;
            3:       atan_rom = 32'sh07200112;
            4:       atan_rom = 32'sh03938AA6;
            5:       atan_rom = 32'sh01CA3795;
            6:       atan_rom = 32'sh00E52A1B;
            7:       atan_rom = 32'sh007296D8;
            8:       atan_rom = 32'sh00394BA5;
            9:       atan_rom = 32'sh001CA5DA;
            10:      atan_rom = 32'sh000E52EE;
            11:      atan_rom = 32'sh00072977;
            12:      atan_rom = 32'sh000394BC;
            13:      atan_rom = 32'sh0001CA5E;
            14:      atan_rom = 32'sh0000E52F;
            15:      atan_rom = 32'sh00007297;
            16:      atan_rom = 32'sh0000394C;
            17:      atan_rom = 32'sh00001CA6;
            18:      atan_rom = 32'sh00000E53;
            19:      atan_rom = 32'sh00000729;
            20:      atan_rom = 32'sh00000395;
            21:      atan_rom = 32'sh000001CA;
            22:      atan_rom = 32'sh000000E5;
            23:      atan_rom = 32'sh00000073;
            24:      atan_rom = 32'sh00000039;
            25:      atan_rom = 32'sh0000001D;
            26:      atan_rom = 32'sh0000000E;
            27:      atan_rom = 32'sh00000007;
            28:      atan_rom = 32'sh00000004;
            29:      atan_rom = 32'sh00000002;
            30:      atan_rom = 32'sh00000001;
            default: atan_rom = 32'sh00000000;
        endcase
    endfunction

    // Fold |angle| > 90 into the converging range; the half-turn is undone
    // by negating both results.
    always_comb begin
        z0   = angle_in;
        neg0 = 1'b0;
        if ($signed(angle_in) > DEG90) begin
            z0   = angle_in - DEG180;
            neg0 = 1'b1;
        end else if ($signed(angle_in) < -DEG90) begin
            z0   = angle_in + DEG180;
            neg0 = 1'b1;
        end
    end

    assign x0 = 32'((64'(mod_in) * 64'(KINV)) >> 32);

    always_comb begin
        atan_i = atan_rom(i);
        x_nx   = x;
        y_nx   = y;
        z_nx   = z;
        if (!z[31]) begin
            x_nx = x - (y >>> i);
            y_nx = y + (x >>> i);
            z_nx = z - atan_i;
        end else begin
            x_nx = x + (y >>> i);
            y_nx = y - (x >>> i);
            z_nx = z + atan_i;
        end
    end

    assign x_out = neg ? -x[31:0] : x[31:0];
    assign y_out = neg ? -y[31:0] : y[31:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (enable) begin
            case (state)
                IDLE:    if (start) state_nx = RUN;
                RUN:     if (i == LAST) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i     <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            neg   <= 1'b0;
            x_res <= '0;
            y_res <= '0;
            done  <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i   <= '0;
                        x   <= {2'b00, x0};
                        y   <= '0;
                        z   <= z0;
                        neg <= neg0;
                    end
                end
                RUN: begin
                    x <= x_nx;
                    y <= y_nx;
                    z <= z_nx;
                    if (i != LAST) i <= i + IW'(1);
                end
                DONE: begin
                    x_res <= x_out;
                    y_res <= y_out;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pol2rec.md
POL2REC -- requirements
Module: pol2rec

Interface
REQ-001 The block SHALL have parameter NITER, default 32, meaning the number of CORDIC rotation iterations per conversion.
REQ-002 The block SHALL have parameter KINV, default 32'h9B74EDA8, meaning the CORDIC gain compensation 1/K = 0.6072529350 in unsigned 0.32 format.
REQ-003 The block SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port enable, input, 1 bit: clock enable; when low, all state and outputs hold.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle request to begin a conversion.
REQ-007 The block SHALL have port mod_in, input, 32 bits: modulus, unsigned 16.16.
REQ-008 The block SHALL have port angle_in, input, 32 bits: angle in degrees, signed 8.24, valid range [-128.0, +128.0).
REQ-009 The block SHALL have port x_res, output, 32 bits: mod*cos(angle), signed 16.16, registered.
REQ-010 The block SHALL have port y_res, output, 32 bits: mod*sin(angle), signed 16.16, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when x_res and y_res are updated.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL transition only on clock edges where enable=1.
REQ-014 In IDLE with start=1 and enable=1, the block SHALL load operands, clear the iteration counter i, set busy=1 and go to RUN.
REQ-015 Load pre-rotation:
- If angle_in > +90.0 (0x5A000000): z0 = angle_in - 180.0 and negate flag = 1.
- If angle_in < -90.0: z0 = angle_in + 180.0 and negate flag = 1.
- Otherwise: z0 = angle_in and negate flag = 0.
REQ-016 Load scaling SHALL be x0 = (mod_in * KINV) >> 32 using a 64-bit unsigned product truncated, with y0 = 0.
REQ-017 The x/y datapath SHALL be 34-bit signed internally (2 guard bits); z SHALL be 32-bit signed 8.24.
REQ-018 Each RUN cycle SHALL update, with all shifts arithmetic:
- If z >= 0: x -= y>>>i, y += x>>>i, z -= ATAN[i].
- Otherwise: x += y>>>i, y -= x>>>i, z += ATAN[i].
REQ-019 ATAN[i] SHALL equal round(atan(2^-i)*180/pi*2^24) for i = 0..NITER-1, with ATAN[0] = 0x2D000000, held in a constant ROM.
REQ-020 After iteration NITER-1, the block SHALL go to DONE and register the results:
- x_res = low 32 bits of x, negated if the negate flag is set; y_res likewise from y.
- done = 1 for exactly one enabled cycle; busy = 0 on the DONE->IDLE transition.
REQ-021 Latency: with enable held high, done SHALL be high in the cycle 33 clock edges after the edge sampling start (1 load + 32 iterations for NITER = 32).
REQ-022 A start received while busy=1 SHALL be ignored, with no restart and no operand reload.
REQ-023 A start in the DONE cycle SHALL be ignored; the block SHALL accept a new start from IDLE on the following cycle.
REQ-024 x_res and y_res SHALL hold their last values until the next DONE, and SHALL remain unchanged during RUN.
REQ-025 When enable=0 mid-RUN, the block SHALL freeze i, x, y, z and the FSM; the latency SHALL extend by exactly the number of disabled cycles.
REQ-026 mod_in = 0 SHALL yield x_res = y_res = 0 exactly.

Reset
REQ-027 While reset=0, asynchronously: state = IDLE, i = 0, x_res = 0, y_res = 0, busy = 0, done = 0, and all internal registers 0.
REQ-028 Reset asserted mid-RUN SHALL abort the conversion with no done pulse; after release the block SHALL accept start normally.

Verification
REQ-029 mod=0x00640000 (100.0), angle=0x00000000 -> done at edge 33; x_res = 0x00640000 ±64 LSB, y_res = 0 ±64 LSB.
REQ-030 mod=0x00640000, angle=0x5A000000 (90.0) -> x_res = 0 ±64 LSB, y_res = 0x00640000 ±64 LSB.
REQ-031 mod=0x008D6BDE (141.421356), angle=0xD3000000 (-45.0) -> x_res = 0x00640000 ±64 LSB, y_res = 0xFF9C0000 ±64 LSB.
REQ-032 mod=0x00640000, angle=0x78000000 (120.0, pre-rotation path) -> x_res = 0xFFCE0000 ±64 LSB, y_res = 0x00569A40 ±64 LSB.
REQ-033 Start, then enable=0 for 5 cycles at iteration 10 -> done at edge 38; a second start during RUN is ignored and the results match the first operands.
REQ-034 Start, then reset low at iteration 10 -> x_res = y_res = 0, busy = 0, no done pulse; a fresh start after release gives correct results.
